// File: rtl/noc_route_decoder.sv
// noc_route_decoder: one node of the NoC binary routing tree.
// Packets are buffered in a small input FIFO. For each packet the routing
// decision is first offered on the select channel, then the packet itself is
// forwarded on the chosen output port.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid_i/in_ready_o/in_data_i        input packet channel
//   sel_valid_o/sel_ready_i/sel_data_o     routing decision (0: port 0, 1: port 1)
//   out0_valid_o/out0_ready_i/out0_data_o  port-0 packet channel
//   out1_valid_o/out1_ready_i/out1_data_o  port-1 packet channel
//   clr_cnt_i                     synchronous clear of both packet counters
//   cnt0_o, cnt1_o                saturating delivered-packet counters
module noc_route_decoder #(
    parameter int unsigned   DW         = 9,
    parameter int unsigned   AW         = 4,
    parameter int unsigned   ADDR_LSB   = 5,
    parameter logic [AW-1:0] NODE_ADDR  = AW'(4'b1110),
    parameter logic [AW-1:0] NODE_MASK  = AW'(4'b1110),
    parameter int unsigned   LEAF       = 0,
    parameter int unsigned   FIFO_DEPTH = 2,
    parameter int unsigned   CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DW-1:0]    in_data_i,
    output logic             sel_valid_o,
    input  logic             sel_ready_i,
    output logic             sel_data_o,
    output logic             out0_valid_o,
    input  logic             out0_ready_i,
    output logic [DW-1:0]    out0_data_o,
    output logic             out1_valid_o,
    input  logic             out1_ready_i,
    output logic [DW-1:0]    out1_data_o,
    input  logic             clr_cnt_i,
    output logic [CNT_W-1:0] cnt0_o,
    output logic [CNT_W-1:0] cnt1_o
);

    // Number of ones in the node mask = depth of this node in the tree.
    function automatic int unsigned mask_ones(input logic [AW-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(AW); i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned K       = mask_ones(NODE_MASK);
    // Tree-level bit examined in non-leaf mode; unused when the mask is all ones.
    localparam int unsigned BIT_IDX = (K < AW) ? (AW - 1 - K) : 0;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    logic [DW-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    state_e           state_q, state_d;
    logic [DW-1:0]    hold_q, hold_d;
    logic             route_q, route_d;
    logic             in_ready_q, in_ready_d;
    logic             sel_valid_q, sel_valid_d;
    logic             sel_data_q, sel_data_d;
    logic             out0_valid_q, out0_valid_d;
    logic             out1_valid_q, out1_valid_d;
    logic [DW-1:0]    out0_data_q, out0_data_d;
    logic [DW-1:0]    out1_data_q, out1_data_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic [DW-1:0] head;
    logic [AW-1:0] head_addr;
    logic          leaf_hit;
    logic          tree_bit;
    logic          route_c;
    logic          push;
    logic          pop;
    logic          sel_xfer;
    logic          out0_xfer;
    logic          out1_xfer;
    logic          fifo_nonempty;

    // Route decision for the FIFO head.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        head_addr = head[ADDR_LSB +: AW];
        leaf_hit  = (head_addr & NODE_MASK) == NODE_ADDR;
        tree_bit  = (K < AW) ? head_addr[BIT_IDX] : 1'b1;
        route_c   = (LEAF != 0) ? !leaf_hit : tree_bit;
    end

    // Dispatcher next state, FIFO bookkeeping, registered output values.
    always_comb begin
        push          = in_valid_i & in_ready_q;
        sel_xfer      = sel_valid_q & sel_ready_i;
        out0_xfer     = out0_valid_q & out0_ready_i;
        out1_xfer     = out1_valid_q & out1_ready_i;
        fifo_nonempty = occ_q != '0;

        pop     = 1'b0;
        state_d = state_q;
        hold_d  = hold_q;
        route_d = route_q;

        case (state_q)
            ST_IDLE: begin
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    hold_d  = head;
                    route_d = route_c;
                    state_d = ST_SEL;
                end
            end
            ST_SEL: begin
                if (sel_xfer) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (out0_xfer | out1_xfer) begin
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        hold_d  = head;
                        route_d = route_c;
                        state_d = ST_SEL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
        in_ready_d = occ_d != FULL_OCC;

        sel_valid_d  = state_d == ST_SEL;
        sel_data_d   = sel_valid_d ? route_d : sel_data_q;
        out0_valid_d = (state_d == ST_DATA) & !route_d;
        out1_valid_d = (state_d == ST_DATA) & route_d;
        out0_data_d  = out0_valid_d ? hold_d : out0_data_q;
        out1_data_d  = out1_valid_d ? hold_d : out1_data_q;

        // Clear wins over a same-cycle delivery; counts stick at all-ones.
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (clr_cnt_i) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else begin
            if (out0_xfer && cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
            if (out1_xfer && cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
        end
    end

    // FIFO storage; contents are meaningless while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            route_q      <= 1'b0;
            in_ready_q   <= 1'b0;
            sel_valid_q  <= 1'b0;
            sel_data_q   <= 1'b0;
            out0_valid_q <= 1'b0;
            out1_valid_q <= 1'b0;
            out0_data_q  <= '0;
            out1_data_q  <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            state_q      <= state_d;
            hold_q       <= hold_d;
            route_q      <= route_d;
            in_ready_q   <= in_ready_d;
            sel_valid_q  <= sel_valid_d;
            sel_data_q   <= sel_data_d;
            out0_valid_q <= out0_valid_d;
            out1_valid_q <= out1_valid_d;
            out0_data_q  <= out0_data_d;
            out1_data_q  <= out1_data_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign in_ready_o   = in_ready_q;
    assign sel_valid_o  = sel_valid_q;
    assign sel_data_o   = sel_data_q;
    assign out0_valid_o = out0_valid_q;
    assign out1_valid_o = out1_valid_q;
    assign out0_data_o  = out0_data_q;
    assign out1_data_o  = out1_data_q;
    assign cnt0_o       = cnt0_q;
    assign cnt1_o       = cnt1_q;

endmodule

// File: tb/tb_noc_route_decoder.sv
// Bench for noc_route_decoder: seven configurations run side by side, each
// with its own packet source and a transaction-level reference model.
module tb_noc_route_decoder;

    localparam int N = 7;

    // 0..4: non-leaf sweep over masks; 5: leaf, 2-bit counters; 6: leaf, depth 4.
    function automatic logic [3:0] mask_of(input int g);
        case (g)
            0:       return 4'b0000;
            1:       return 4'b1000;
            2:       return 4'b1100;
            4:       return 4'b1111;
            default: return 4'b1110;
        endcase
    endfunction
    function automatic int unsigned leaf_of(input int g);  return (g >= 5) ? 1 : 0;  endfunction
    function automatic int unsigned depth_of(input int g); return (g == 6) ? 4 : 2;  endfunction
    function automatic int unsigned cntw_of(input int g);  return (g == 5) ? 2 : 16; endfunction

    logic clk;
    logic rst_n;
    logic [N-1:0] in_valid, sel_ready, out0_ready, out1_ready, clr_cnt;
    logic [8:0]   in_data [N];
    wire  [N-1:0] in_ready, sel_valid, sel_data, out0_valid, out1_valid;
    wire  [8:0]   out0_data [N];
    wire  [8:0]   out1_data [N];
    wire  [15:0]  cnt0 [N];
    wire  [15:0]  cnt1 [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int unsigned CW = cntw_of(g);
        logic [CW-1:0] c0, c1;
        noc_route_decoder #(
            .DW(9), .AW(4), .ADDR_LSB(5),
            .NODE_ADDR(4'b1110), .NODE_MASK(mask_of(g)), .LEAF(leaf_of(g)),
            .FIFO_DEPTH(depth_of(g)), .CNT_W(CW)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid_i(in_valid[g]), .in_ready_o(in_ready[g]), .in_data_i(in_data[g]),
            .sel_valid_o(sel_valid[g]), .sel_ready_i(sel_ready[g]), .sel_data_o(sel_data[g]),
            .out0_valid_o(out0_valid[g]), .out0_ready_i(out0_ready[g]), .out0_data_o(out0_data[g]),
            .out1_valid_o(out1_valid[g]), .out1_ready_i(out1_ready[g]), .out1_data_o(out1_data[g]),
            .clr_cnt_i(clr_cnt[g]), .cnt0_o(c0), .cnt1_o(c1)
        );
        assign cnt0[g] = 16'(c0);
        assign cnt1[g] = 16'(c1);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state (per configuration).
    logic [8:0] txb [N][32];
    int         tx_h [N], tx_t [N];
    logic [8:0] pb [N][16];
    int         p_h [N], p_t [N];
    logic [8:0] cur [N];
    bit         await_q [N];
    int         outst [N];
    int         exp_c0 [N], exp_c1 [N];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rnd_mode = 0, rnd_clr = 0, sr_fix = 0, or_fix = 0;
    bit clr_all = 0, clr_on_o0 = 0, clr_hit = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Routing rule straight from the node definition.
    function automatic logic ref_route(input int g, input logic [8:0] pkt);
        logic [3:0] addr, m, sh;
        int k;
        addr = pkt[8:5];
        m    = mask_of(g);
        if (leaf_of(g) != 0) return ((addr & m) == 4'b1110) ? 1'b0 : 1'b1;
        k = 0;
        for (int i = 0; i < 4; i++) if (m[i]) k++;
        if (k == 4) return 1'b1;
        sh = addr >> (3 - k);
        return sh[0];
    endfunction

    task automatic model_reset();
        for (int g = 0; g < N; g++) begin
            tx_h[g] = 0; tx_t[g] = 0; p_h[g] = 0; p_t[g] = 0;
            cur[g] = '0; await_q[g] = 0; outst[g] = 0; exp_c0[g] = 0; exp_c1[g] = 0;
        end
    endtask

    task automatic enq(input int g, input logic [8:0] d);
        txb[g][tx_t[g] % 32] = d;
        tx_t[g]++;
    endtask

    task automatic enq_all(input logic [3:0] addr);
        for (int g = 0; g < N; g++) enq(g, {addr, 5'($urandom)});
    endtask

    function automatic int busy_cnt();
        int s;
        s = 0;
        for (int g = 0; g < N; g++) s += (tx_t[g] - tx_h[g]) + outst[g];
        return s;
    endfunction

    // One cycle: check outputs, drive inputs, advance the model on transfers.
    task automatic step();
        @(negedge clk);
        cyc++;
        for (int g = 0; g < N; g++) begin
            chk("cnt0", int'(cnt0[g]), exp_c0[g]);
            chk("cnt1", int'(cnt1[g]), exp_c1[g]);
            chk("excl", int'({sel_valid[g] & (out0_valid[g] | out1_valid[g]),
                              out0_valid[g] & out1_valid[g]}), 0);
            if (sel_valid[g]) begin
                chk("sel_phase", int'(await_q[g]), 0);
                chk("sel_pending", int'(p_t[g] > p_h[g]), 1);
                if (p_t[g] > p_h[g])
                    chk("sel_data", int'(sel_data[g]), int'(ref_route(g, pb[g][p_h[g] % 16])));
            end
            if (out0_valid[g] | out1_valid[g]) begin
                chk("out_phase", int'(await_q[g]), 1);
                if (await_q[g]) begin
                    chk("out_port", int'(out1_valid[g]), int'(ref_route(g, cur[g])));
                    chk("out_data", int'(out1_valid[g] ? out1_data[g] : out0_data[g]), int'(cur[g]));
                end
            end
            if (outst[g] >= int'(depth_of(g)) + 1) chk("in_ready_full", int'(in_ready[g]), 0);
        end
        for (int g = 0; g < N; g++) begin
            in_valid[g]   = tx_t[g] > tx_h[g];
            in_data[g]    = in_valid[g] ? txb[g][tx_h[g] % 32] : 9'h000;
            sel_ready[g]  = rnd_mode ? ($urandom_range(0, 3) != 0) : sr_fix;
            out0_ready[g] = rnd_mode ? ($urandom_range(0, 3) != 0) : or_fix;
            out1_ready[g] = rnd_mode ? ($urandom_range(0, 3) != 0) : or_fix;
            clr_cnt[g]    = clr_all | (rnd_mode & rnd_clr & ($urandom_range(0, 31) == 0))
                          | (clr_on_o0 & out0_valid[g] & out0_ready[g]);
        end
        for (int g = 0; g < N; g++) begin
            bit ox0, ox1;
            int mx;
            if (sel_valid[g] && sel_ready[g] && p_t[g] > p_h[g]) begin
                cur[g] = pb[g][p_h[g] % 16];
                p_h[g]++;
                await_q[g] = 1;
            end
            if (in_valid[g] && in_ready[g]) begin
                pb[g][p_t[g] % 16] = in_data[g];
                p_t[g]++;
                tx_h[g]++;
                outst[g]++;
                chk("occupancy", int'(outst[g] <= int'(depth_of(g)) + 1), 1);
            end
            ox0 = out0_valid[g] & out0_ready[g];
            ox1 = out1_valid[g] & out1_ready[g];
            if ((ox0 | ox1) && await_q[g]) begin
                await_q[g] = 0;
                outst[g]--;
            end
            mx = (1 << cntw_of(g)) - 1;
            if (clr_cnt[g]) begin
                if (g == 5 && ox0) clr_hit = 1;
                exp_c0[g] = 0;
                exp_c1[g] = 0;
            end else begin
                if (ox0 && exp_c0[g] < mx) exp_c0[g]++;
                if (ox1 && exp_c1[g] < mx) exp_c1[g]++;
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (busy_cnt() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain", busy_cnt(), 0);
        step();
    endtask

    task automatic check_reset();
        for (int g = 0; g < N; g++) begin
            chk("rst_in_ready", int'(in_ready[g]), 0);
            chk("rst_sel_valid", int'(sel_valid[g]), 0);
            chk("rst_sel_data", int'(sel_data[g]), 0);
            chk("rst_out_valid", int'({out0_valid[g], out1_valid[g]}), 0);
            chk("rst_out0_data", int'(out0_data[g]), 0);
            chk("rst_out1_data", int'(out1_data[g]), 0);
            chk("rst_cnt", int'(cnt0[g]) + int'(cnt1[g]), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "bench timeout");
    end

    initial begin
        int sel_at, out_at, cnt_at, base;
        rst_n = 1'b0;
        in_valid = '0; sel_ready = '0; out0_ready = '0; out1_ready = '0; clr_cnt = '0;
        for (int g = 0; g < N; g++) in_data[g] = '0;
        model_reset();

        @(negedge clk);
        check_reset();
        rst_n = 1'b1;
        step();
        for (int g = 0; g < N; g++) chk("in_ready_rel", int'(in_ready[g]), 1);

        // Latency on the default node: 1110 -> port 0, then 1111 -> port 1.
        sr_fix = 1; or_fix = 1;
        enq_all(4'b1110);
        step();
        chk("lat_push", tx_t[3] - tx_h[3], 0);
        base = int'(cnt0[3]);
        sel_at = -1; out_at = -1; cnt_at = -1;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (sel_valid[3] && sel_at < 0) sel_at = c;
            if (out0_valid[3] && out_at < 0) out_at = c;
            if (int'(cnt0[3]) != base && cnt_at < 0) cnt_at = c;
        end
        chk("lat_sel", sel_at, 2);
        chk("lat_out", out_at, 3);
        chk("lat_cnt", cnt_at, 4);
        enq_all(4'b1111);
        drain(50);
        chk("second_pkt_cnt1", int'(cnt1[3]), 1);

        // Randomized traffic, backpressure and counter clears.
        rnd_mode = 1; rnd_clr = 1;
        for (int i = 0; i < 600; i++) begin
            for (int g = 0; g < N; g++)
                if (tx_t[g] - tx_h[g] < 3 && $urandom_range(0, 1) == 1) enq(g, 9'($urandom));
            step();
        end
        rnd_mode = 0; rnd_clr = 0;
        sr_fix = 1; or_fix = 1;
        drain(200);

        // Leaf decisions: 1110, 1111 -> port 0; 0110 -> port 1.
        clr_all = 1; step(); clr_all = 0;
        enq_all(4'b1110); enq_all(4'b1111); enq_all(4'b0110);
        drain(60);
        chk("leaf_cnt0", int'(cnt0[5]), 2);
        chk("leaf_cnt1", int'(cnt1[5]), 1);
        chk("leaf4_cnt0", int'(cnt0[6]), 2);

        // Select channel stalled: FIFO fills, in_ready drops.
        sr_fix = 0; or_fix = 1;
        for (int k = 0; k < 4; k++) enq_all(4'($urandom));
        repeat (10) step();
        for (int g = 0; g < N; g++) begin
            chk("bp_accept", 4 - (tx_t[g] - tx_h[g]), (depth_of(g) == 2) ? 3 : 4);
            if (depth_of(g) == 2) chk("bp_in_ready", int'(in_ready[g]), 0);
        end
        sr_fix = 1;
        drain(80);

        // Reset while holding a packet in DATA with two more buffered.
        sr_fix = 1; or_fix = 0;
        enq_all(4'b1110); enq_all(4'b1111); enq_all(4'b0001);
        repeat (8) step();
        chk("pre_rst_data", int'(out0_valid[3] | out1_valid[3]), 1);
        chk("pre_rst_ready", int'(in_ready[3]), 0);
        #2 rst_n = 1'b0;
        #1 check_reset();
        model_reset();
        in_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        or_fix = 1;
        repeat (10) step();
        enq_all(4'b1111);
        drain(50);
        chk("post_rst_cnt1", int'(cnt1[3]), 1);
        chk("post_rst_cnt0", int'(cnt0[3]), 0);

        // Counter saturation, then clear colliding with a port-0 delivery.
        clr_all = 1; step(); clr_all = 0;
        for (int k = 0; k < 5; k++) enq_all(4'b1110);
        drain(100);
        chk("sat_cnt0", int'(cnt0[5]), 3);
        chk("nosat_cnt0", int'(cnt0[3]), 5);
        clr_on_o0 = 1; clr_hit = 0;
        enq_all(4'b1110);
        drain(50);
        clr_on_o0 = 0;
        chk("clr_coincide", int'(clr_hit), 1);
        chk("clr_prio_cnt0", int'(cnt0[5]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
